ibex_sram_arbiter: RTL and testbench

- Shares one single-port SRAM (1-cycle read latency, ram_1p-style) between the Ibex instruction and data ports.
- Implements the Ibex req/gnt/rvalid protocol on both sides.
- Applies address-window decode and returns an error response for out-of-window accesses.
- Instruction fetch has default priority. A starvation counter guarantees the data port is granted within bounded time.
- Sits between ibex_top and the SRAM in FPGA example tops. Replaces ad-hoc combinational muxing there.

---
 rtl/ibex_sram_arbiter_if.sv | 52 +++++
 rtl/ibex_sram_arbiter.sv | 117 +++++++++++
 tb/tb_ibex_sram_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_sram_arbiter_if.sv
// ibex_sram_arbiter_if
// Bundles the Ibex instruction port, the Ibex data port and the single-port
// SRAM port into one interface.
//   instr_*: fetch req/gnt/rvalid/err plus address and read data
//   data_* : data req/gnt/rvalid/err plus we, be, address, write and read data
//   mem_*  : SRAM request, write, byte enables, address, write data, read data
// Modports:
//   slave  - arbiter view (takes requests, drives grants/responses and the SRAM)
//   master - environment view (cores and SRAM model)
interface ibex_sram_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/ibex_sram_arbiter.sv
// ibex_sram_arbiter
// Shares one single-port SRAM (1-cycle read latency) between the Ibex
// instruction and data ports.
// Ports:
//   clk_i - system clock
//   rst_i - asynchronous active-high reset
//   bus   - ibex_sram_arbiter_if.slave (instr_*, data_*, mem_* signals)
// Handshake: a request is accepted in the cycle where req and gnt are both
// high (gnt is combinational from req). Every accepted request produces
// exactly one rvalid pulse on the same port in the following cycle, with
// err set for out-of-window addresses. Fetch wins ties unless the data port
// has been denied for MaxStarve consecutive cycles.
module ibex_sram_arbiter #(
  parameter logic [31:0] MemStart  = 32'h00000000,
  parameter logic [31:0] MemMask   = 32'h0000FFFF,
  parameter int unsigned MaxStarve = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  ibex_sram_arbiter_if.slave bus
);

  localparam logic [4:0] MAX_STARVE = 5'(MaxStarve);

  logic [3:0] r_starve;
  logic       r_rsp_valid;
  logic       r_rsp_owner_data;
  logic       r_rsp_err;

  logic w_instr_gnt;
  logic w_data_gnt;
  logic w_any_gnt;
  logic w_instr_in_win;
  logic w_data_in_win;
  logic w_win_err;
  logic w_data_prio;

  assign w_instr_in_win = (bus.instr_addr_i & ~MemMask) == MemStart;
  assign w_data_in_win  = (bus.data_addr_i  & ~MemMask) == MemStart;

  // starve >= MaxStarve, written as starve+1 > MaxStarve so that
  // MaxStarve=0 does not produce a constant comparison.
  assign w_data_prio = ({1'b0, r_starve} + 5'd1) > MAX_STARVE;

  // Grants are suppressed while reset is held.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_i) begin
      if (bus.data_req_i && (!bus.instr_req_i || w_data_prio)) begin
        w_data_gnt = 1'b1;
      end else if (bus.instr_req_i) begin
        w_instr_gnt = 1'b1;
      end
    end
  end

  assign w_any_gnt = w_instr_gnt | w_data_gnt;
  assign w_win_err = w_data_gnt ? ~w_data_in_win : ~w_instr_in_win;

  // SRAM side: only granted in-window accesses reach the memory; fetches
  // never write.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0;
    bus.mem_addr_o  = 32'b0;
    bus.mem_wdata_o = 32'b0;
    if (w_data_gnt && w_data_in_win) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_be_o    = bus.data_be_i;
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else if (w_instr_gnt && w_instr_in_win) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_addr_o  = bus.instr_addr_i;
    end
  end

  // Counts consecutive cycles the data port asked and was refused.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= 4'd0;
    end else if (!bus.data_req_i || w_data_gnt) begin
      r_starve <= 4'd0;
    end else if (r_starve != 4'hF) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Response pipeline stage: one entry, reloaded every cycle, so
  // back-to-back grants stream at one access per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid      <= 1'b0;
      r_rsp_owner_data <= 1'b0;
      r_rsp_err        <= 1'b0;
    end else begin
      r_rsp_valid      <= w_any_gnt;
      r_rsp_owner_data <= w_data_gnt;
      r_rsp_err        <= w_any_gnt & w_win_err;
    end
  end

  assign bus.instr_gnt_o    = w_instr_gnt;
  assign bus.data_gnt_o     = w_data_gnt;

  assign bus.instr_rvalid_o = r_rsp_valid & ~r_rsp_owner_data;
  assign bus.instr_err_o    = bus.instr_rvalid_o & r_rsp_err;
  assign bus.instr_rdata_o  = (bus.instr_rvalid_o && !r_rsp_err) ? bus.mem_rdata_i : 32'b0;

  assign bus.data_rvalid_o  = r_rsp_valid & r_rsp_owner_data;
  assign bus.data_err_o     = bus.data_rvalid_o & r_rsp_err;
  assign bus.data_rdata_o   = (bus.data_rvalid_o && !r_rsp_err) ? bus.mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// tb_ibex_sram_arbiter
// Directed bench for ibex_sram_arbiter. The driver issues one request
// pattern per cycle, checks grants and the SRAM bus in that cycle, and
// pushes the expected response into exp_q; a monitor on the falling edge
// pops and compares whenever either rvalid is high. A second instance with
// MaxStarve=0 covers the data-priority configuration.
module tb_ibex_sram_arbiter;

  localparam logic [31:0] RD_KEY    = 32'h5A5A0000;
  localparam logic [31:0] WR_RDATA  = 32'hBADBAD00;
  localparam logic [31:0] MEM_MASK  = 32'h0000FFFF;

  logic clk;
  logic rst;

  ibex_sram_arbiter_if bus0();
  ibex_sram_arbiter_if bus1();

  ibex_sram_arbiter #(.MemStart(32'h0), .MemMask(MEM_MASK), .MaxStarve(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  ibex_sram_arbiter #(.MemStart(32'h0), .MemMask(MEM_MASK), .MaxStarve(0)) u_dut_p0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data is a known function of the read address; writes
  // and idle cycles return a fixed marker.
  always @(posedge clk) begin
    if (bus0.mem_req_o && !bus0.mem_we_o) bus0.mem_rdata_i <= bus0.mem_addr_o ^ RD_KEY;
    else                                   bus0.mem_rdata_i <= WR_RDATA;
  end
  assign bus1.mem_rdata_i = 32'h0;

  // ---------------- scoreboard ----------------
  // entry: {is_data, err, rdata}
  logic [33:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit drop_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a & ~MEM_MASK) == 32'h0;
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus0.instr_rvalid_o || bus0.data_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got instr=%0b data=%0b expected none at %0t",
                 bus0.instr_rvalid_o, bus0.data_rvalid_o, $time);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_valids", {30'b0, bus0.instr_rvalid_o, bus0.data_rvalid_o},
              {30'b0, ~e[33], e[33]});
        check("rsp_errs", {30'b0, bus0.instr_err_o, bus0.data_err_o},
              {30'b0, ~e[33] & e[32], e[33] & e[32]});
        if (e[33]) begin
          check("data_rdata", bus0.data_rdata_o, e[31:0]);
          check("instr_rdata_idle", bus0.instr_rdata_o, 32'h0);
        end else begin
          check("instr_rdata", bus0.instr_rdata_o, e[31:0]);
          check("data_rdata_idle", bus0.data_rdata_o, 32'h0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] db,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic eig, input logic edg, input string tag);
    logic win;
    @(posedge clk);
    #1;
    bus0.instr_req_i  = ir;
    bus0.instr_addr_i = ia;
    bus0.data_req_i   = dr;
    bus0.data_we_i    = dw;
    bus0.data_be_i    = db;
    bus0.data_addr_i  = da;
    bus0.data_wdata_i = dwd;
    #1;
    check({tag, "_igt"}, {31'b0, bus0.instr_gnt_o}, {31'b0, eig});
    check({tag, "_dgt"}, {31'b0, bus0.data_gnt_o}, {31'b0, edg});
    if (edg) begin
      win = in_win(da);
      check({tag, "_mreq"}, {31'b0, bus0.mem_req_o}, {31'b0, win});
      if (win) begin
        check({tag, "_maddr"}, bus0.mem_addr_o, da);
        check({tag, "_mwe_be"}, {27'b0, bus0.mem_we_o, bus0.mem_be_o}, {27'b0, dw, db});
        check({tag, "_mwdata"}, bus0.mem_wdata_o, dwd);
      end else begin
        check({tag, "_maddr0"}, bus0.mem_addr_o, 32'h0);
      end
      if (!drop_next)
        exp_q.push_back({1'b1, ~win, (!win) ? 32'h0 : (dw ? WR_RDATA : (da ^ RD_KEY))});
    end else if (eig) begin
      win = in_win(ia);
      check({tag, "_mreq"}, {31'b0, bus0.mem_req_o}, {31'b0, win});
      if (win) begin
        check({tag, "_maddr"}, bus0.mem_addr_o, ia);
        check({tag, "_mwe_be"}, {27'b0, bus0.mem_we_o, bus0.mem_be_o}, 32'h0);
        check({tag, "_mwdata"}, bus0.mem_wdata_o, 32'h0);
      end
      if (!drop_next)
        exp_q.push_back({1'b0, ~win, win ? (ia ^ RD_KEY) : 32'h0});
    end else begin
      check({tag, "_mreq_idle"}, {31'b0, bus0.mem_req_o}, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, "idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus0.instr_req_i = 1'b1; bus0.instr_addr_i = 32'h40;
    bus0.data_req_i  = 1'b1; bus0.data_we_i = 1'b0; bus0.data_be_i = 4'h0;
    bus0.data_addr_i = 32'h44; bus0.data_wdata_i = 32'h0;
    bus1.instr_req_i = 1'b0; bus1.instr_addr_i = 32'h0;
    bus1.data_req_i  = 1'b0; bus1.data_we_i = 1'b0; bus1.data_be_i = 4'h0;
    bus1.data_addr_i = 32'h0; bus1.data_wdata_i = 32'h0;

    // Reset held with both requests asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnts", {30'b0, bus0.instr_gnt_o, bus0.data_gnt_o}, 32'h0);
    check("rst_rvalids", {30'b0, bus0.instr_rvalid_o, bus0.data_rvalid_o}, 32'h0);
    check("rst_mem", {bus0.mem_req_o, bus0.mem_we_o, bus0.mem_be_o, bus0.mem_addr_o[25:0]}, 32'h0);
    check("rst_mem_wdata", bus0.mem_wdata_o, 32'h0);
    bus0.instr_req_i = 1'b0;
    bus0.data_req_i  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // First cycle after release: both request, fetch wins.
    cyc(1, 32'h40, 1, 0, 4'h0, 32'h44, 32'h0, 1, 0, "rel");
    idle(1);

    // Back-to-back fetches.
    cyc(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "f80");
    cyc(1, 32'h84, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "f84");
    cyc(1, 32'h88, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "f88");

    // Data write, partial byte enables (also overlaps last fetch response).
    cyc(0, 32'h0, 1, 1, 4'b0011, 32'h00001000, 32'hDEADBEEF, 0, 1, "wr");
    // Out-of-window data read.
    cyc(0, 32'h0, 1, 0, 4'hF, 32'h00010000, 32'h0, 0, 1, "oow_d");
    // Out-of-window fetch.
    cyc(1, 32'h00020004, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "oow_i");
    // In-window data read and a zero-byte-enable write.
    cyc(0, 32'h0, 1, 0, 4'hF, 32'h00002000, 32'h0, 0, 1, "rd");
    cyc(0, 32'h0, 1, 1, 4'h0, 32'h00003000, 32'h12345678, 0, 1, "wr_be0");
    idle(1);

    // Both requesting continuously: 4 fetch grants then 1 data grant, twice.
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4)
        cyc(1, 32'h100 + 32'(i * 4), 1, 0, 4'hF, 32'h200 + 32'(i * 4), 32'h0, 0, 1, "starve");
      else
        cyc(1, 32'h100 + 32'(i * 4), 1, 0, 4'hF, 32'h200 + 32'(i * 4), 32'h0, 1, 0, "starve");
    end
    // Data request withdrawn for one cycle clears the count.
    cyc(1, 32'h140, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "drop");
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        cyc(1, 32'h150, 1, 0, 4'hF, 32'h250, 32'h0, 0, 1, "restarve");
      else
        cyc(1, 32'h150, 1, 0, 4'hF, 32'h250, 32'h0, 1, 0, "restarve");
    end
    idle(1);

    // MaxStarve=0 instance: data wins every cycle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus1.instr_req_i = 1'b1; bus1.instr_addr_i = 32'h300;
      bus1.data_req_i  = 1'b1; bus1.data_addr_i  = 32'h400;
      #1;
      check("p0_gnts", {30'b0, bus1.instr_gnt_o, bus1.data_gnt_o}, 32'h1);
      if (i > 0) check("p0_rvalid", {30'b0, bus1.instr_rvalid_o, bus1.data_rvalid_o}, 32'h1);
    end
    @(posedge clk);
    #1;
    bus1.instr_req_i = 1'b0;
    bus1.data_req_i  = 1'b0;

    // Grant, then reset in the response cycle: response is dropped.
    drop_next = 1'b1;
    cyc(1, 32'h500, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "pre_rst");
    drop_next = 1'b0;
    @(posedge clk);
    #1;
    bus0.instr_req_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", {30'b0, bus0.instr_rvalid_o, bus0.data_rvalid_o}, 32'h0);
    cyc(1, 32'h600, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, "post_rst");
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
